sram_responder: RTL and testbench

- Synthesizable on-chip responder for the 16-bit external SRAM interface that the SLC-3 top level drives through CE, UB, LB, OE, WE, ADDR and the bidirectional Data bus.
- Sits on the memory side of that bus. It replaces the physical SRAM in simulation and in FPGA builds without board SRAM.
- Adds a configurable read latency, a power-up clear, and a program-load port that preloads LC-3 code before the CPU starts fetching.

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_responder_if.sv | 32 +++
 rtl/sram_array.sv | 30 +++
 rtl/sram_responder.sv | 122 ++++++++++++
 tb/tb_sram_responder.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder slice.
// Imported by the responder, its RAM array and benches.
package sram_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_SERVE
    } state_e;

    typedef logic [1:0] lane_t;

    localparam int MEM_WORD_W = 16;

    localparam logic [15:0] LC3_LOAD_BASE = 16'h3000;

    // Bus lane pins are active low; the array wants an active-high mask.
    function automatic lane_t lane_mask(
        input logic ub_n,
        input logic lb_n
    );
        return {~ub_n, ~lb_n};
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// SRAM control pins plus the program-load handshake.
// The CPU side is the master; the responder is the slave.
interface sram_responder_if #(
    parameter int ADDR_W  = 20,
    parameter int DEPTH_W = 10
);

    logic               CE;
    logic               UB;
    logic               LB;
    logic               OE;
    logic               WE;
    logic [ADDR_W-1:0]  ADDR;
    logic               ld_valid;
    logic               ld_ready;
    logic [DEPTH_W-1:0] ld_addr;
    logic [15:0]        ld_data;
    logic               busy;

    modport master (
        output CE, UB, LB, OE, WE, ADDR,
        output ld_valid, ld_addr, ld_data,
        input  ld_ready, busy
    );

    modport slave (
        input  CE, UB, LB, OE, WE, ADDR,
        input  ld_valid, ld_addr, ld_data,
        output ld_ready, busy
    );

endinterface

// File: rtl/sram_array.sv
// Byte-enabled single-port RAM with a registered read port.
// Read-first: a write and a read on the same edge return the old word.
module sram_array
    import sram_pkg::*;
#(
    parameter int DEPTH_W = 10
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  lane_t                 be_i,
    input  logic [DEPTH_W-1:0]    addr_i,
    input  logic [MEM_WORD_W-1:0] wdata_i,
    output logic [MEM_WORD_W-1:0] rdata_o
);

    localparam int WORDS = 1 << DEPTH_W;

    logic [MEM_WORD_W-1:0] mem_q [WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i && be_i[1]) begin
            mem_q[addr_i][15:8] <= wdata_i[15:8];
        end
        if (we_i && be_i[0]) begin
            mem_q[addr_i][7:0] <= wdata_i[7:0];
        end
        rdata_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/sram_responder.sv
// Memory-side responder for the SLC-3 SRAM bus: power-up clear,
// read latency, byte lanes and a program-load port.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int DEPTH_W  = 10,
    parameter int READ_LAT = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    sram_responder_if.slave       bus,
    inout  wire [MEM_WORD_W-1:0]  Data
);

    localparam int LAT_W = 3;
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(READ_LAT);

    state_e             state_q, state_d;
    logic [DEPTH_W-1:0] clr_q, clr_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;

    logic                  serve;
    logic                  wr_req;
    logic                  rd_req;
    logic                  rd_hit;
    logic                  ld_fire;
    logic                  drive_en;
    lane_t                 bus_lanes;

    logic                  mem_we;
    lane_t                 mem_be;
    logic [DEPTH_W-1:0]    mem_addr;
    logic [MEM_WORD_W-1:0] mem_wdata;
    logic [MEM_WORD_W-1:0] mem_rdata;

    assign serve     = (state_q == ST_SERVE);
    assign bus_lanes = lane_mask(bus.UB, bus.LB);
    assign wr_req    = serve && !bus.CE && !bus.WE;
    assign rd_req    = serve && !bus.CE && bus.WE && !bus.OE;
    assign rd_hit    = (lat_q != '0) && (bus.ADDR == rd_addr_q);
    assign ld_fire   = serve && bus.CE && bus.ld_valid;
    assign drive_en  = rd_req && rd_hit && (lat_q == LAT_MAX);

    assign bus.ld_ready = serve && bus.CE;
    assign bus.busy     = !serve;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_CLEAR;
            clr_q     <= '0;
            lat_q     <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            lat_q     <= lat_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_d     = clr_q;
        lat_d     = lat_q;
        rd_addr_d = rd_addr_q;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = bus.ADDR[DEPTH_W-1:0];
        mem_wdata = Data;

        unique case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_be    = 2'b11;
                mem_addr  = clr_q;
                mem_wdata = '0;
                clr_d     = clr_q + 1'b1;
                if (&clr_q) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (wr_req) begin
                    mem_we = |bus_lanes;
                    mem_be = bus_lanes;
                end else if (ld_fire) begin
                    mem_we    = 1'b1;
                    mem_be    = 2'b11;
                    mem_addr  = bus.ld_addr;
                    mem_wdata = bus.ld_data;
                end

                // A new address restarts the count at one on this edge.
                if (!rd_req) begin
                    lat_d = '0;
                end else if (!rd_hit) begin
                    lat_d     = LAT_W'(1);
                    rd_addr_d = bus.ADDR;
                end else if (lat_q != LAT_MAX) begin
                    lat_d = lat_q + 1'b1;
                end
            end
        endcase
    end

    sram_array #(
        .DEPTH_W (DEPTH_W)
    ) u_array (
        .clk_i   (Clk),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    assign Data[15:8] = (drive_en && !bus.UB) ? mem_rdata[15:8] : 8'hzz;
    assign Data[7:0]  = (drive_en && !bus.LB) ? mem_rdata[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Directed plus randomized bench for sram_responder against a word-array model.
// Data carries pull-ups, so an undriven byte reads back as 8'hFF.
module tb_sram_responder;

    localparam int AW = 20;
    localparam int DW = 4;
    localparam int RL = 2;
    localparam int NW = 1 << DW;
    localparam logic [15:0] ZZ = 16'hFFFF;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    wire  [15:0] Data;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_wdata = '0;

    int passes = 0;
    int checks = 0;

    logic [15:0] model [NW];

    sram_responder_if #(.ADDR_W(AW), .DEPTH_W(DW)) bus ();

    sram_responder #(
        .ADDR_W   (AW),
        .DEPTH_W  (DW),
        .READ_LAT (RL)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave),
        .Data  (Data)
    );

    assign Data = tb_drv ? tb_wdata : 16'hzzzz;

    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (Data[g]);
    end

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.CE       = 1'b1;
        bus.WE       = 1'b1;
        bus.OE       = 1'b1;
        bus.UB       = 1'b1;
        bus.LB       = 1'b1;
        bus.ld_valid = 1'b0;
        tb_drv       = 1'b0;
    endtask

    function automatic logic [15:0] on_bus(input logic [15:0] v,
                                           input logic ub, input logic lb);
        return {ub ? 8'hFF : v[15:8], lb ? 8'hFF : v[7:0]};
    endfunction

    task automatic do_write(input logic [19:0] a, input logic [15:0] d,
                            input logic ub, input logic lb);
        int idx;
        bus.ADDR = a;
        bus.CE   = 1'b0;
        bus.WE   = 1'b0;
        bus.OE   = 1'($urandom_range(0, 1));
        bus.UB   = ub;
        bus.LB   = lb;
        tb_drv   = 1'b1;
        tb_wdata = d;
        step();
        idx = int'(a) % NW;
        if (!ub) model[idx][15:8] = d[15:8];
        if (!lb) model[idx][7:0] = d[7:0];
        idle();
        step();
    endtask

    task automatic do_read(input string tag, input logic [19:0] a,
                           input logic ub, input logic lb,
                           input logic [15:0] exp);
        bus.ADDR = a;
        bus.CE   = 1'b0;
        bus.WE   = 1'b1;
        bus.OE   = 1'b0;
        bus.UB   = ub;
        bus.LB   = lb;
        #1;
        for (int i = 0; i < RL; i++) begin
            chk({tag, "_lat"}, Data, ZZ);
            step();
        end
        chk(tag, Data, exp);
        idle();
        step();
    endtask

    task automatic do_load(input logic [3:0] a, input logic [15:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        #1;
        chk("ld_ready", bus.ld_ready, 1);
        step();
        model[a] = d;
    endtask

    initial begin
        int          n;
        logic [19:0] a;
        logic [15:0] d;
        logic        ub, lb;
        int          r;

        for (int i = 0; i < NW; i++) model[i] = '0;
        idle();
        bus.ADDR    = '0;
        bus.ld_addr = '0;
        bus.ld_data = '0;

        step();
        step();
        chk("rst_busy", bus.busy, 1);
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_data", Data, ZZ);

        // A load offered during the clear must be ignored.
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 4'd2;
        bus.ld_data  = 16'hBEEF;
        Reset = 1'b1;
        n = 0;
        while (bus.busy && n < 100) begin
            if (n == 3) chk("clr_ld_ready", bus.ld_ready, 0);
            step();
            n++;
        end
        chk("clear_cycles", n, NW);
        bus.ld_valid = 1'b0;
        chk("serve_ld_ready", bus.ld_ready, 1);

        for (int i = 0; i < NW; i++) begin
            a = {4'($urandom), 12'h0, 4'(i)};
            do_read("clr_read", a, 1'b0, 1'b0, 16'h0000);
        end

        do_write(20'h00074, 16'h3002, 1'b0, 1'b0);
        bus.ADDR = 20'h00074;
        bus.CE   = 1'b0;
        bus.WE   = 1'b1;
        bus.OE   = 1'b0;
        bus.UB   = 1'b0;
        bus.LB   = 1'b0;
        #1;
        chk("rd74_pre", Data, ZZ);
        step();
        chk("rd74_edge1", Data, ZZ);
        step();
        chk("rd74_edge2", Data, 16'h3002);
        step();
        chk("rd74_hold", Data, 16'h3002);
        bus.ADDR = 20'h00075;
        #1;
        chk("rd74_addr_change", Data, ZZ);
        idle();
        step();

        do_write(20'h00005, 16'h1234, 1'b0, 1'b0);
        do_write(20'h00005, 16'hABCD, 1'b0, 1'b1);
        do_read("lane_lo", 20'h00005, 1'b1, 1'b0, 16'hFF34);
        do_read("lane_full", 20'h00005, 1'b0, 1'b0, 16'hAB34);
        do_write(20'h00005, 16'h7777, 1'b1, 1'b1);
        do_read("lane_none", 20'h00005, 1'b0, 1'b0, 16'hAB34);

        do_write(20'h00401, 16'h5555, 1'b0, 1'b0);
        do_read("alias", 20'h00001, 1'b0, 1'b0, 16'h5555);

        bus.CE       = 1'b0;
        bus.WE       = 1'b1;
        bus.OE       = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 4'd3;
        bus.ld_data  = 16'h0FFF;
        #1;
        chk("ld_blocked_ready", bus.ld_ready, 0);
        step();
        bus.ADDR = 20'h00003;
        bus.OE   = 1'b0;
        bus.UB   = 1'b0;
        bus.LB   = 1'b0;
        for (int i = 0; i < RL; i++) step();
        chk("ld_blocked_nowrite", Data, 16'h0000);
        idle();
        bus.ld_valid = 1'b1;
        #1;
        chk("ld_accept_ready", bus.ld_ready, 1);
        step();
        model[3] = 16'h0FFF;
        idle();
        step();
        do_read("ld_read", 20'h00003, 1'b0, 1'b0, 16'h0FFF);

        for (int i = 0; i < 250; i++) begin
            r  = int'($urandom_range(0, 9));
            a  = 20'($urandom);
            d  = 16'($urandom);
            ub = 1'($urandom_range(0, 1));
            lb = 1'($urandom_range(0, 1));
            if (r < 4) begin
                do_write(a, d, ub, lb);
            end else if (r < 7) begin
                do_read("rnd_read", a, ub, lb,
                        on_bus(model[int'(a) % NW], ub, lb));
            end else if (r < 9) begin
                n = int'($urandom_range(1, 4));
                for (int k = 0; k < n; k++) begin
                    do_load(4'($urandom), 16'($urandom));
                end
                idle();
                step();
            end else begin
                bus.ADDR = a;
                bus.WE   = 1'b0;
                bus.OE   = 1'b0;
                bus.UB   = 1'b0;
                bus.LB   = 1'b0;
                tb_drv   = 1'b1;
                tb_wdata = d;
                #1;
                chk("stray_nodrive", Data, d);
                step();
                idle();
                step();
            end
        end

        do_write(20'h00007, 16'h1357, 1'b0, 1'b0);
        bus.ADDR = 20'h00007;
        bus.CE   = 1'b0;
        bus.WE   = 1'b1;
        bus.OE   = 1'b0;
        bus.UB   = 1'b0;
        bus.LB   = 1'b0;
        for (int i = 0; i < RL; i++) step();
        chk("prereset_data", Data, 16'h1357);
        Reset = 1'b0;
        #1;
        chk("midrst_data", Data, ZZ);
        chk("midrst_busy", bus.busy, 1);
        step();
        step();
        Reset = 1'b1;
        n = 0;
        while (bus.busy && n < 100) begin
            if (n == 5) chk("clr_read_ignored", Data, ZZ);
            step();
            n++;
        end
        chk("clear_cycles_2", n, NW);
        for (int i = 0; i < NW; i++) model[i] = '0;
        idle();
        step();
        do_read("postrst_7", 20'h00007, 1'b0, 1'b0, 16'h0000);
        do_read("postrst_74", 20'h00074, 1'b0, 1'b0, 16'h0000);
        do_read("postrst_3", 20'h00003, 1'b0, 1'b0, 16'h0000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
